// File: rtl/exp2n.sv
// exp2n: iterative IEEE-754 single-precision base-2 exponential, y = 2^x.
//
// x is split into a signed integer part k and a fraction f in [0,1).
// 2^f is built by shift-and-multiply over a ROM of 2^(2^-i), one fraction
// bit per cycle. k is then packed into the exponent field.
//
// Optional build macro:
//   EXP2_ROUND_EN - round the mantissa to nearest-even in PACK. A rounding
//                   carry can bump the exponent, and that can overflow to
//                   +inf. When the macro is undefined the mantissa is
//                   truncated. Latency is the same in both builds.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; x is latched when start is accepted
// UNPACK | classify x, floor it to Q8.FRAC_BITS, set acc = 1.0, i = 1
// ITER   | FRAC_BITS cycles; multiply acc by C[i] when f bit 2^-i is set
// PACK   | normalise and round, write y/ovf/unf, pulse done
module exp2n #(
    parameter int FRAC_BITS = 24,
    parameter int ACC_BITS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf
);

    // Fixed-point x: sign, 8 integer bits, FRAC_BITS fraction bits.
    localparam int FX_W = FRAC_BITS + 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        ITER   = 2'd2,
        PACK   = 2'd3
    } state_t;

    state_t                state;
    logic [31:0]           x_q;
    logic signed [8:0]     k_q;
    logic [FRAC_BITS-1:0]  f_sh;
    logic [ACC_BITS:0]     acc;
    logic [4:0]            i_idx;
    logic                  spec_q;
    logic [31:0]           spec_y;
    logic                  spec_ovf;
    logic                  spec_unf;

    // C[i] = 2^(2^-i) in Q1.32, floored. Index 0 and out-of-range give 1.0.
    function automatic logic [32:0] c_rom(input logic [4:0] idx);
        case (idx)
            5'd1:    c_rom = 33'h1_6A09E667;
            5'd2:    c_rom = 33'h1_306FE0A3;
            5'd3:    c_rom = 33'h1_172B83C7;
            5'd4:    c_rom = 33'h1_0B5586CF;
            5'd5:    c_rom = 33'h1_059B0D31;
            5'd6:    c_rom = 33'h1_02C9A3E7;
            5'd7:    c_rom = 33'h1_0163DA9F;
            5'd8:    c_rom = 33'h1_00B1AFA5;
            5'd9:    c_rom = 33'h1_0058C86D;
            5'd10:   c_rom = 33'h1_002C605E;
            5'd11:   c_rom = 33'h1_00162F39;
            5'd12:   c_rom = 33'h1_000B175E;
            5'd13:   c_rom = 33'h1_00058BA0;
            5'd14:   c_rom = 33'h1_0002C5CC;
            5'd15:   c_rom = 33'h1_000162E5;
            5'd16:   c_rom = 33'h1_0000B172;
            5'd17:   c_rom = 33'h1_000058B9;
            5'd18:   c_rom = 33'h1_00002C5C;
            5'd19:   c_rom = 33'h1_0000162E;
            5'd20:   c_rom = 33'h1_00000B17;
            5'd21:   c_rom = 33'h1_0000058B;
            5'd22:   c_rom = 33'h1_000002C5;
            5'd23:   c_rom = 33'h1_00000162;
            5'd24:   c_rom = 33'h1_000000B1;
            default: c_rom = 33'h1_00000000;
        endcase
    endfunction

    logic [23:0]           sig;
    logic [FX_W+23:0]      lsh_wide;
    logic [23:0]           rsh_sig;
    logic [FX_W-1:0]       mag;
    logic [FX_W-1:0]       fx;
    logic                  sticky;
    int                    sh_amt;
    logic signed [8:0]     unp_k;
    logic [FRAC_BITS-1:0]  unp_f;

    // Floor the latched x to signed Q8.FRAC_BITS. Bits shifted out of a
    // negative operand push it one LSB further toward -inf.
    always_comb begin
        sig      = {1'b1, x_q[22:0]};
        sh_amt   = int'(x_q[30:23]) + FRAC_BITS - 150;
        lsh_wide = '0;
        rsh_sig  = '0;
        mag      = '0;
        sticky   = 1'b0;
        if (sh_amt >= 0) begin
            lsh_wide = {{FX_W{1'b0}}, sig} << sh_amt;
            mag      = lsh_wide[FX_W-1:0];
        end else if (sh_amt > -24) begin
            rsh_sig = sig >> (-sh_amt);
            mag     = FX_W'(rsh_sig);
            sticky  = |(sig & ((24'd1 << (-sh_amt)) - 24'd1));
        end else begin
            sticky = 1'b1;
        end
        fx    = x_q[31] ? -(mag + FX_W'(sticky)) : mag;
        unp_k = fx[FX_W-1:FRAC_BITS];
        unp_f = fx[FRAC_BITS-1:0];
    end

    logic [ACC_BITS+32:0]   c_wide;
    logic [ACC_BITS:0]      c_tab;
    logic [2*ACC_BITS+1:0]  prod;
    logic [ACC_BITS:0]      mul_next;

    // One multiply step: acc * C[i] rescaled to Q1.ACC_BITS, truncated.
    always_comb begin
        c_wide   = {c_rom(i_idx), {ACC_BITS{1'b0}}};
        c_tab    = c_wide[ACC_BITS+32:32];
        prod     = {{(ACC_BITS+1){1'b0}}, acc} * {{(ACC_BITS+1){1'b0}}, c_tab};
        mul_next = prod[2*ACC_BITS:ACC_BITS];
    end

    logic [8:0]   exp_b;
    logic [8:0]   exp_r;
    logic [23:0]  mant_r;
    logic         rnd;
    logic [31:0]  pack_y;
    logic         pack_ovf;

    // Pack acc in [1,2) and k into a float. A rounding carry into the
    // exponent can reach 255, which saturates to +inf.
    always_comb begin
        exp_b = $unsigned(k_q) + 9'd127;
        rnd   = 1'b0;
`ifdef EXP2_ROUND_EN
        rnd   = acc[ACC_BITS-24] & ((|acc[ACC_BITS-25:0]) | acc[ACC_BITS-23]);
`endif
        mant_r = {1'b0, acc[ACC_BITS-1:ACC_BITS-23]} + {23'd0, rnd};
        exp_r  = exp_b + {8'd0, mant_r[23]};
        if (exp_r >= 9'd255) begin
            pack_y   = 32'h7F80_0000;
            pack_ovf = 1'b1;
        end else begin
            pack_y   = {1'b0, exp_r[7:0], mant_r[22:0]};
            pack_ovf = 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lsh_wide[FX_W+23:FX_W], c_wide[31:0], prod[2*ACC_BITS+1],
                           prod[ACC_BITS-1:0], acc[ACC_BITS], acc[ACC_BITS-24:0]};

    // Sequencer: handshake, classification, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            y        <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            x_q      <= '0;
            k_q      <= '0;
            f_sh     <= '0;
            acc      <= '0;
            i_idx    <= '0;
            spec_q   <= 1'b0;
            spec_y   <= '0;
            spec_ovf <= 1'b0;
            spec_unf <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    spec_q   <= 1'b1;
                    spec_ovf <= 1'b0;
                    spec_unf <= 1'b0;
                    state    <= PACK;
                    if (x_q[30:23] == 8'hFF) begin
                        if (x_q[22:0] != 23'd0) spec_y <= 32'h7FC0_0000;
                        else if (x_q[31])        spec_y <= 32'h0000_0000;
                        else                     spec_y <= 32'h7F80_0000;
                    end else if (x_q[30:23] == 8'h00) begin
                        spec_y <= 32'h3F80_0000;
                    end else if (x_q[30:23] >= 8'd134) begin
                        // |x| >= 128
                        if (x_q[31]) begin
                            spec_y   <= 32'h0000_0000;
                            spec_unf <= 1'b1;
                        end else begin
                            spec_y   <= 32'h7F80_0000;
                            spec_ovf <= 1'b1;
                        end
                    end else if (unp_k < -9'sd126) begin
                        spec_y   <= 32'h0000_0000;
                        spec_unf <= 1'b1;
                    end else begin
                        spec_q <= 1'b0;
                        k_q    <= unp_k;
                        f_sh   <= unp_f;
                        acc    <= {1'b1, {ACC_BITS{1'b0}}};
                        i_idx  <= 5'd1;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (f_sh[FRAC_BITS-1]) acc <= mul_next;
                    f_sh  <= f_sh << 1;
                    i_idx <= i_idx + 5'd1;
                    if (i_idx == 5'(FRAC_BITS)) state <= PACK;
                end
                PACK: begin
                    if (spec_q) begin
                        y   <= spec_y;
                        ovf <= spec_ovf;
                        unf <= spec_unf;
                    end else begin
                        y   <= pack_y;
                        ovf <= pack_ovf;
                        unf <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp2n.sv
// Directed bench for exp2n with hand-computed results.
module tb_exp2n;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        ovf;
    logic        unf;

    int n_chk  = 0;
    int n_fail = 0;

    exp2n dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at the negedge after the accepting edge with n = n0 edges elapsed.
    // Returns n = edges from the accepting edge to done, and busy-low count.
    task automatic wait_done(input int n0, output int n, output int busy_low);
        n = n0;
        busy_low = 0;
        while (done !== 1'b1 && n < 64) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            n++;
        end
    endtask

    // Issues start at the current negedge (may be the done cycle of the last op).
    task automatic op(input string tag, input logic [31:0] xv, input int lat,
                      input logic [31:0] ye, input logic oe, input logic ue);
        int n;
        int bl;
        start = 1'b1;
        x     = xv;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, n, bl);
        check({tag, " done"},    32'(done), 32'd1);
        check({tag, " latency"}, 32'(n),    32'(lat));
        check({tag, " y"},       y,         ye);
        check({tag, " ovf"},     32'(ovf),  32'(oe));
        check({tag, " unf"},     32'(unf),  32'(ue));
        check({tag, " busy_hi"}, 32'(bl),   32'd0);
        check({tag, " busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int bl;
        int dcount;

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset y",    y,         32'd0);
        check("reset ovf",  32'(ovf),  32'd0);
        check("reset unf",  32'(unf),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal path, exact powers of two and fractional results.
        op("x=3.0",    32'h4040_0000, 26, 32'h4100_0000, 1'b0, 1'b0);
        op("x=-1.0",   32'hBF80_0000, 26, 32'h3F00_0000, 1'b0, 1'b0);
        op("x=-126.0", 32'hC2FC_0000, 26, 32'h0080_0000, 1'b0, 1'b0);
        op("x=0.5",    32'h3F00_0000, 26, 32'h3FB5_04F3, 1'b0, 1'b0);
        op("x=-0.5",   32'hBF00_0000, 26, 32'h3F35_04F3, 1'b0, 1'b0);
        op("x=0.25",   32'h3E80_0000, 26, 32'h3F98_37F0, 1'b0, 1'b0);
        op("x=1.5",    32'h3FC0_0000, 26, 32'h4035_04F3, 1'b0, 1'b0);
        op("x=127.0",  32'h42FE_0000, 26, 32'h7F00_0000, 1'b0, 1'b0);

        // Special classes and range limits.
        op("x=128.0",  32'h4300_0000, 2, 32'h7F80_0000, 1'b1, 1'b0);
        op("x=-127.0", 32'hC2FE_0000, 2, 32'h0000_0000, 1'b0, 1'b1);
        op("x=-126.5", 32'hC2FD_0000, 2, 32'h0000_0000, 1'b0, 1'b1);
        op("x=NaN",    32'h7FC0_0001, 2, 32'h7FC0_0000, 1'b0, 1'b0);
        op("x=-0",     32'h8000_0000, 2, 32'h3F80_0000, 1'b0, 1'b0);
        op("x=denorm", 32'h0000_0001, 2, 32'h3F80_0000, 1'b0, 1'b0);
        op("x=-inf",   32'hFF80_0000, 2, 32'h0000_0000, 1'b0, 1'b0);
        op("x=+inf",   32'h7F80_0000, 2, 32'h7F80_0000, 1'b0, 1'b0);

        // Start while busy is ignored; restart in the done cycle is taken.
        start = 1'b1;
        x     = 32'h4040_0000;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (9) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        x     = 32'h40A0_0000;
        @(negedge clk);
        n++;
        start = 1'b0;
        x     = '0;
        wait_done(n, n, bl);
        check("ignored start done",    32'(done), 32'd1);
        check("ignored start latency", 32'(n),    32'd26);
        check("ignored start y",       y,         32'h4100_0000);
        op("restart x=5.0", 32'h40A0_0000, 26, 32'h4200_0000, 1'b0, 1'b0);

        // Reset mid-operation abandons the result.
        start = 1'b1;
        x     = 32'h3F00_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst y",    y,         32'd0);
        check("midrst ovf",  32'(ovf),  32'd0);
        check("midrst unf",  32'(unf),  32'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("midrst no done", 32'(dcount), 32'd0);
        op("x=1.0 after rst", 32'h3F80_0000, 26, 32'h4000_0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
